// File: rtl/mem_arb_pkg.sv
// -----------------------------------------------------------------------------
// mem_arb_pkg
// Shared definitions for the memory bus arbiter:
//   - ArbState   : arbiter FSM states (IDLE, ISSUE, DONE, HOLD)
//   - REQ_*      : requester index assignment on the packed request buses
// -----------------------------------------------------------------------------
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DONE  = 2'd2,
        HOLD  = 2'd3
    } ArbState;

    localparam int REQ_VIDEO  = 0;
    localparam int REQ_IFETCH = 1;
    localparam int REQ_DATA   = 2;

endpackage

// File: rtl/mem_bus_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin picker. Searches upward from i_last+1 with
// modulo-NUM_REQ wrap and returns the first requesting index. When i_prio0 is
// set and the video requester is asking, the video requester wins outright;
// otherwise everybody (video included) takes part in the rotation.
//
// Ports:
//   i_req    [NUM_REQ]  request vector
//   i_last   [IDX_W]    index of the previous owner
//   i_prio0  1          video priority override enable
//   o_onehot [NUM_REQ]  one-hot winner (0 when i_req is 0)
//   o_idx    [IDX_W]    winner index (0 when i_req is 0)
// -----------------------------------------------------------------------------
module rr_pick
    import mem_arb_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_last,
    input  logic               i_prio0,
    output logic [NUM_REQ-1:0] o_onehot,
    output logic [IDX_W-1:0]   o_idx
);

    logic [NUM_REQ-1:0] w_cand;
    logic               w_found;
    logic [IDX_W-1:0]   w_k;
    int                 w_pos;

    always_comb begin
        w_cand = i_req;
        // Override: reduce the candidate set to the video requester alone.
        if (i_prio0 && i_req[REQ_VIDEO]) begin
            w_cand            = '0;
            w_cand[REQ_VIDEO] = 1'b1;
        end

        o_onehot = '0;
        o_idx    = '0;
        w_found  = 1'b0;
        w_pos    = 0;
        w_k      = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            w_pos = (int'(i_last) + i) % NUM_REQ;
            w_k   = IDX_W'(w_pos);
            if (!w_found && w_cand[w_k]) begin
                w_found       = 1'b1;
                o_onehot[w_k] = 1'b1;
                o_idx         = w_k;
            end
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// -----------------------------------------------------------------------------
// mem_bus_arbiter
// Shares one single-port memory among NUM_REQ requesters (0 video, 1 CPU
// fetch, 2 CPU data) with round-robin arbitration and a per-requester lock
// that keeps the grant across a read-modify-write pair.
//
// Handshake: a requester holds i_req and its fields stable until it sees its
// o_ack bit for one cycle. Towards memory, o_mem_* are held stable while
// o_mem_req is high, and the transfer completes on the edge where i_mem_ack
// is sampled high (may be the first cycle of o_mem_req).
//
// Optional build macro: MEM_ARB_PRIO0_EN - video (requester 0) wins every
// IDLE arbitration whenever it requests; locks are still honoured.
//
// Ports:
//   i_clk, i_rst (async, active-low)
//   i_req/i_lock/i_we [NUM_REQ], i_addr/i_wdata/i_be  packed per requester
//   o_grant [NUM_REQ] current owner, o_ack [NUM_REQ] completion pulse,
//   o_rdata [DATA_W]  read data valid with o_ack
//   o_mem_req/we/addr/wdata/be  memory request, i_mem_ack/i_mem_rdata reply
// -----------------------------------------------------------------------------
module mem_bus_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic [NUM_REQ-1:0]          i_req,
    input  logic [NUM_REQ-1:0]          i_lock,
    input  logic [NUM_REQ-1:0]          i_we,
    input  logic [NUM_REQ*ADDR_W-1:0]   i_addr,
    input  logic [NUM_REQ*DATA_W-1:0]   i_wdata,
    input  logic [NUM_REQ*DATA_W/8-1:0] i_be,
    output logic [NUM_REQ-1:0]          o_grant,
    output logic [NUM_REQ-1:0]          o_ack,
    output logic [DATA_W-1:0]           o_rdata,
    output logic                        o_mem_req,
    output logic                        o_mem_we,
    output logic [ADDR_W-1:0]           o_mem_addr,
    output logic [DATA_W-1:0]           o_mem_wdata,
    output logic [DATA_W/8-1:0]         o_mem_be,
    input  logic                        i_mem_ack,
    input  logic [DATA_W-1:0]           i_mem_rdata
);

    localparam int BE_W  = DATA_W / 8;
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

`ifdef MEM_ARB_PRIO0_EN
    localparam logic PRIO0_EN = 1'b1;
`else
    localparam logic PRIO0_EN = 1'b0;
`endif

    ArbState             r_state;
    logic [IDX_W-1:0]    r_owner;
    logic [IDX_W-1:0]    r_last_owner;
    logic [NUM_REQ-1:0]  r_grant;
    logic [NUM_REQ-1:0]  r_ack;
    logic [DATA_W-1:0]   r_rdata;
    logic                r_mem_req;
    logic                r_mem_we;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [DATA_W-1:0]   r_mem_wdata;
    logic [BE_W-1:0]     r_mem_be;

    logic [NUM_REQ-1:0]  w_win_onehot;
    logic [IDX_W-1:0]    w_win_idx;
    logic [IDX_W-1:0]    w_src_idx;
    logic [ADDR_W-1:0]   w_addr_arr  [NUM_REQ];
    logic [DATA_W-1:0]   w_wdata_arr [NUM_REQ];
    logic [BE_W-1:0]     w_be_arr    [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign w_addr_arr[g]  = i_addr[g*ADDR_W +: ADDR_W];
        assign w_wdata_arr[g] = i_wdata[g*DATA_W +: DATA_W];
        assign w_be_arr[g]    = i_be[g*BE_W +: BE_W];
    end

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .i_req    (i_req),
        .i_last   (r_last_owner),
        .i_prio0  (PRIO0_EN),
        .o_onehot (w_win_onehot),
        .o_idx    (w_win_idx)
    );

    // In HOLD the owner reissues without arbitration, so its own fields are
    // latched; in IDLE the fresh winner's fields are.
    assign w_src_idx = (r_state == HOLD) ? r_owner : w_win_idx;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state      <= IDLE;
            r_owner      <= '0;
            r_last_owner <= IDX_W'(NUM_REQ - 1);
            r_grant      <= '0;
            r_ack        <= '0;
            r_rdata      <= '0;
            r_mem_req    <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_mem_be     <= '0;
        end else begin
            r_ack <= '0;
            case (r_state)
                IDLE: begin
                    if (|i_req) begin
                        r_owner     <= w_win_idx;
                        r_grant     <= w_win_onehot;
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= i_we[w_src_idx];
                        r_mem_addr  <= w_addr_arr[w_src_idx];
                        r_mem_wdata <= w_wdata_arr[w_src_idx];
                        r_mem_be    <= w_be_arr[w_src_idx];
                        r_state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (i_mem_ack) begin
                        r_mem_req    <= 1'b0;
                        r_rdata      <= i_mem_rdata;
                        r_ack        <= r_grant;
                        r_last_owner <= r_owner;
                        r_state      <= DONE;
                    end
                end
                DONE: begin
                    if (i_lock[r_owner]) begin
                        r_state <= HOLD;
                    end else begin
                        r_grant <= '0;
                        r_state <= IDLE;
                    end
                end
                HOLD: begin
                    if (i_req[r_owner]) begin
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= i_we[w_src_idx];
                        r_mem_addr  <= w_addr_arr[w_src_idx];
                        r_mem_wdata <= w_wdata_arr[w_src_idx];
                        r_mem_be    <= w_be_arr[w_src_idx];
                        r_state     <= ISSUE;
                    end else if (!i_lock[r_owner]) begin
                        r_grant <= '0;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_grant     = r_grant;
    assign o_ack       = r_ack;
    assign o_rdata     = r_rdata;
    assign o_mem_req   = r_mem_req;
    assign o_mem_we    = r_mem_we;
    assign o_mem_addr  = r_mem_addr;
    assign o_mem_wdata = r_mem_wdata;
    assign o_mem_be    = r_mem_be;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_bus_arbiter
// Directed scenarios plus randomized traffic for mem_bus_arbiter. A simple
// memory responder with programmable wait cycles lives in the step task; a
// transaction-level reference (winner selection by rotation arithmetic,
// latency = wait + 1 cycles from issue to ack) checks the random run.
// -----------------------------------------------------------------------------
module tb_mem_bus_arbiter;

    localparam int NUM_REQ = 3;
    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int BE_W    = DATA_W / 8;

    logic                      i_clk = 1'b0;
    logic                      i_rst;
    logic [NUM_REQ-1:0]        i_req;
    logic [NUM_REQ-1:0]        i_lock;
    logic [NUM_REQ-1:0]        i_we;
    logic [NUM_REQ*ADDR_W-1:0] i_addr;
    logic [NUM_REQ*DATA_W-1:0] i_wdata;
    logic [NUM_REQ*BE_W-1:0]   i_be;
    logic [NUM_REQ-1:0]        o_grant;
    logic [NUM_REQ-1:0]        o_ack;
    logic [DATA_W-1:0]         o_rdata;
    logic                      o_mem_req;
    logic                      o_mem_we;
    logic [ADDR_W-1:0]         o_mem_addr;
    logic [DATA_W-1:0]         o_mem_wdata;
    logic [BE_W-1:0]           o_mem_be;
    logic                      i_mem_ack;
    logic [DATA_W-1:0]         i_mem_rdata;

    mem_bus_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W)
    ) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_req       (i_req),
        .i_lock      (i_lock),
        .i_we        (i_we),
        .i_addr      (i_addr),
        .i_wdata     (i_wdata),
        .i_be        (i_be),
        .o_grant     (o_grant),
        .o_ack       (o_ack),
        .o_rdata     (o_rdata),
        .o_mem_req   (o_mem_req),
        .o_mem_we    (o_mem_we),
        .o_mem_addr  (o_mem_addr),
        .o_mem_wdata (o_mem_wdata),
        .o_mem_be    (o_mem_be),
        .i_mem_ack   (i_mem_ack),
        .i_mem_rdata (i_mem_rdata)
    );

    // ---------------- clock ----------------
    always #5 i_clk = ~i_clk;

    // ---------------- bench state ----------------
    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int mem_wait = 0;
    int wait_cnt = 0;
    logic [DATA_W-1:0]  mem_model [logic [ADDR_W-1:0]];
    logic [NUM_REQ-1:0] issue_grant_q [$];
    logic               issue_we_q    [$];
    logic [NUM_REQ-1:0] ack_seen;
    logic [NUM_REQ-1:0] prev_ack;
    logic               prev_mem_req;

    function automatic logic [DATA_W-1:0] mem_read(input logic [ADDR_W-1:0] a);
        if (mem_model.exists(a)) return mem_model[a];
        return a ^ 32'h5A5A_0000;
    endfunction

    // Reference winner: first requester after 'last' in rotation order.
    function automatic int ref_pick(input logic [NUM_REQ-1:0] req, input int last);
`ifdef MEM_ARB_PRIO0_EN
        if (req[0]) return 0;
`endif
        for (int d = 1; d <= NUM_REQ; d++) begin
            if (req[(last + d) % NUM_REQ]) return (last + d) % NUM_REQ;
        end
        return -1;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic set_req(input int k, input logic req, input logic lock, input logic we,
                           input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wdata,
                           input logic [BE_W-1:0] be);
        i_req[k]                    = req;
        i_lock[k]                   = lock;
        i_we[k]                     = we;
        i_addr[k*ADDR_W +: ADDR_W]  = addr;
        i_wdata[k*DATA_W +: DATA_W] = wdata;
        i_be[k*BE_W +: BE_W]        = be;
    endtask

    task automatic new_txn(input int k);
        logic [ADDR_W-1:0] a;
        a = ADDR_W'($urandom_range(0, 15)) << 2;
        set_req(k, 1'b1, 1'b0, 1'($urandom_range(0, 1)), a, $urandom, BE_W'($urandom_range(1, 15)));
    endtask

    task automatic clear_logs();
        issue_grant_q.delete();
        issue_we_q.delete();
        ack_seen     = '0;
        prev_ack     = '0;
        prev_mem_req = 1'b0;
        wait_cnt     = 0;
        i_mem_ack    = 1'b0;
        i_mem_rdata  = '0;
    endtask

    task automatic apply_reset();
        i_rst  = 1'b0;
        i_req  = '0; i_lock = '0; i_we = '0;
        i_addr = '0; i_wdata = '0; i_be = '0;
        mem_wait = 0;
        clear_logs();
        repeat (2) @(posedge i_clk);
        #1;
        i_rst = 1'b1;
    endtask

    // One clock: sample outputs 1 time unit after the edge, log issues/acks,
    // then the memory responder decides i_mem_ack for the next edge.
    task automatic step();
        logic [DATA_W-1:0] tmp;
        @(posedge i_clk);
        #1;
        cyc++;
        if (prev_ack != '0) begin
            checks++;
            if (o_ack !== '0) begin
                errors++;
                $display("FAIL ack_width: o_ack=%b on consecutive cycles, required 000", o_ack);
            end
        end
        if (o_mem_req && !prev_mem_req) begin
            issue_grant_q.push_back(o_grant);
            issue_we_q.push_back(o_mem_we);
        end
        ack_seen     = ack_seen | o_ack;
        prev_ack     = o_ack;
        prev_mem_req = o_mem_req;
        if (o_mem_req) begin
            if (wait_cnt >= mem_wait) begin
                i_mem_ack   = 1'b1;
                i_mem_rdata = mem_read(o_mem_addr);
                if (o_mem_we) begin
                    tmp = mem_read(o_mem_addr);
                    for (int b = 0; b < BE_W; b++)
                        if (o_mem_be[b]) tmp[b*8 +: 8] = o_mem_wdata[b*8 +: 8];
                    mem_model[o_mem_addr] = tmp;
                end
            end else begin
                i_mem_ack = 1'b0;
                wait_cnt++;
            end
        end else begin
            i_mem_ack = 1'b0;
            wait_cnt  = 0;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        i_rst = 1'b0;
        i_req = '1; i_lock = '0; i_we = '1;
        i_addr = '1; i_wdata = '1; i_be = '1;
        i_mem_ack = 1'b1; i_mem_rdata = '1;
        repeat (2) @(posedge i_clk);
        #1;
        checks++;
        if ({o_grant, o_ack, o_mem_req, o_mem_we} !== '0) begin
            errors++;
            $display("FAIL reset_ctrl: grant=%b ack=%b mem_req=%b we=%b, required all 0",
                     o_grant, o_ack, o_mem_req, o_mem_we);
        end
        checks++;
        if ({o_mem_addr, o_mem_wdata, o_mem_be, o_rdata} !== '0) begin
            errors++;
            $display("FAIL reset_data: addr=%h wdata=%h be=%h rdata=%h, required all 0",
                     o_mem_addr, o_mem_wdata, o_mem_be, o_rdata);
        end
        i_req = '0; i_we = '0; i_addr = '0; i_wdata = '0; i_be = '0;
        clear_logs();
        i_rst = 1'b1;
        repeat (2) step();
        checks++;
        if ({o_grant, o_mem_req} !== '0) begin
            errors++;
            $display("FAIL idle_no_req: grant=%b mem_req=%b, required 000 0", o_grant, o_mem_req);
        end
    endtask

    task automatic test_single_read();
        apply_reset();
        mem_model[32'h0000_FFFC] = 32'h1234_5678;
        set_req(1, 1'b1, 1'b0, 1'b0, 32'h0000_FFFC, '0, 4'hF);
        step();
        checks++;
        if ({o_mem_req, o_grant, o_ack} !== {1'b1, 3'b010, 3'b000} || o_mem_addr !== 32'h0000_FFFC) begin
            errors++;
            $display("FAIL single_issue: req=%b grant=%b ack=%b addr=%h, required 1 010 000 0000fffc",
                     o_mem_req, o_grant, o_ack, o_mem_addr);
        end
        step();
        checks++;
        if ({o_mem_req, o_ack} !== {1'b0, 3'b010}) begin
            errors++;
            $display("FAIL single_ack: mem_req=%b ack=%b, required 0 010", o_mem_req, o_ack);
        end
        checks++;
        if (o_rdata !== 32'h1234_5678) begin
            errors++;
            $display("FAIL single_rdata: got %h, required 12345678", o_rdata);
        end
        set_req(1, 1'b0, 1'b0, 1'b0, '0, '0, '0);
        step();
        checks++;
        if ({o_ack, o_grant} !== '0) begin
            errors++;
            $display("FAIL single_release: ack=%b grant=%b, required 000 000", o_ack, o_grant);
        end
    endtask

    task automatic test_saturation();
        int last;
        int w;
        apply_reset();
        mem_wait = 2;
        for (int k = 0; k < NUM_REQ; k++)
            set_req(k, 1'b1, 1'b0, 1'b0, ADDR_W'(k * 256), '0, 4'hF);
        for (int n = 0; n < 80 && issue_grant_q.size() < 4; n++) step();
        checks++;
        if (issue_grant_q.size() < 4) begin
            errors++;
            $display("FAIL sat_timeout: %0d grants seen, required 4", issue_grant_q.size());
        end else begin
            last = NUM_REQ - 1;
            for (int i = 0; i < 4; i++) begin
                w    = ref_pick(3'b111, last);
                last = w;
                checks++;
                if (issue_grant_q[i] !== NUM_REQ'(1) << w) begin
                    errors++;
                    $display("FAIL sat_order[%0d]: grant=%b, required %b", i, issue_grant_q[i], NUM_REQ'(1) << w);
                end
            end
        end
    endtask

    task automatic test_lock_rmw();
        logic [NUM_REQ-1:0] exp_g [3];
        logic               exp_w [3];
        exp_g[0] = 3'b100; exp_g[1] = 3'b100; exp_g[2] = 3'b001;
        exp_w[0] = 1'b0;   exp_w[1] = 1'b1;   exp_w[2] = 1'b0;
        apply_reset();
        mem_wait = 1;
        mem_model[32'h10] = 32'hAABB_CCDD;
        set_req(2, 1'b1, 1'b1, 1'b0, 32'h10, '0, 4'hF);
        for (int n = 0; n < 20 && !o_ack[2]; n++) step();
        checks++;
        if (o_ack[2] !== 1'b1 || o_rdata !== 32'hAABB_CCDD) begin
            errors++;
            $display("FAIL rmw_read: ack=%b rdata=%h, required 100 aabbccdd", o_ack, o_rdata);
        end
        // Write half of the RMW, with video now pending as a competitor.
        set_req(2, 1'b1, 1'b1, 1'b1, 32'h10, 32'h0000_0077, 4'b0001);
        set_req(0, 1'b1, 1'b0, 1'b0, 32'h200, '0, 4'hF);
        step();
        for (int n = 0; n < 20 && !o_ack[2]; n++) step();
        set_req(2, 1'b0, 1'b0, 1'b0, '0, '0, '0);
        step();
        for (int n = 0; n < 20 && !o_ack[0]; n++) step();
        checks++;
        if (issue_grant_q.size() != 3) begin
            errors++;
            $display("FAIL rmw_count: %0d issues, required 3", issue_grant_q.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (issue_grant_q[i] !== exp_g[i] || issue_we_q[i] !== exp_w[i]) begin
                    errors++;
                    $display("FAIL rmw_seq[%0d]: grant=%b we=%b, required %b %b",
                             i, issue_grant_q[i], issue_we_q[i], exp_g[i], exp_w[i]);
                end
            end
        end
        checks++;
        if (mem_model[32'h10] !== 32'hAABB_CC77) begin
            errors++;
            $display("FAIL rmw_mem: got %h, required aabbcc77", mem_model[32'h10]);
        end
        set_req(0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
        repeat (2) step();
    endtask

    task automatic test_withdrawal();
        apply_reset();
        mem_wait = 3;
        set_req(2, 1'b1, 1'b0, 1'b0, 32'h40, '0, 4'hF);
        for (int n = 0; n < 10 && !o_mem_req; n++) step();
        // Pulse video for one cycle and drop requester 2 mid-transfer.
        set_req(0, 1'b1, 1'b0, 1'b0, 32'h80, '0, 4'hF);
        i_req[2] = 1'b0;
        step();
        i_req[0] = 1'b0;
        for (int n = 0; n < 20 && !ack_seen[2]; n++) step();
        repeat (8) step();
        checks++;
        if (ack_seen !== 3'b100) begin
            errors++;
            $display("FAIL withdraw_ack: acks seen %b, required 100", ack_seen);
        end
        checks++;
        if (issue_grant_q.size() != 1 || issue_grant_q[0] !== 3'b100) begin
            errors++;
            $display("FAIL withdraw_grant: %0d issues, first=%b, required 1 issue 100",
                     issue_grant_q.size(), (issue_grant_q.size() > 0) ? issue_grant_q[0] : 3'b000);
        end
    endtask

    task automatic test_reset_mid_transfer();
        apply_reset();
        mem_wait = 6;
        for (int k = 0; k < NUM_REQ; k++)
            set_req(k, 1'b1, 1'b0, 1'b0, ADDR_W'(k * 16), '0, 4'hF);
        for (int n = 0; n < 10 && !o_mem_req; n++) step();
        checks++;
        if (o_grant !== 3'b001) begin
            errors++;
            $display("FAIL rstmid_first: grant=%b, required 001", o_grant);
        end
        #2;
        i_rst     = 1'b0;
        i_mem_ack = 1'b0;
        #1;
        checks++;
        if ({o_mem_req, o_grant} !== '0) begin
            errors++;
            $display("FAIL rstmid_async: mem_req=%b grant=%b, required 0 000", o_mem_req, o_grant);
        end
        @(posedge i_clk);
        #1;
        clear_logs();
        mem_wait = 0;
        i_rst    = 1'b1;
        for (int n = 0; n < 10 && issue_grant_q.size() == 0; n++) step();
        checks++;
        if (issue_grant_q.size() == 0 || issue_grant_q[0] !== 3'b001) begin
            errors++;
            $display("FAIL rstmid_after: first grant=%b, required 001",
                     (issue_grant_q.size() > 0) ? issue_grant_q[0] : 3'b000);
        end
        i_req = '0;
        repeat (4) step();
    endtask

    task automatic test_prio0();
        logic [NUM_REQ-1:0] exp_g [6];
`ifdef MEM_ARB_PRIO0_EN
        for (int i = 0; i < 6; i++) exp_g[i] = 3'b001;
`else
        exp_g[0] = 3'b001; exp_g[1] = 3'b010; exp_g[2] = 3'b100;
        exp_g[3] = 3'b001; exp_g[4] = 3'b010; exp_g[5] = 3'b100;
`endif
        apply_reset();
        for (int k = 0; k < NUM_REQ; k++)
            set_req(k, 1'b1, 1'b0, 1'b0, ADDR_W'(k * 4), '0, 4'hF);
        for (int n = 0; n < 60 && issue_grant_q.size() < 6; n++) step();
        checks++;
        if (issue_grant_q.size() < 6) begin
            errors++;
            $display("FAIL prio_timeout: %0d grants seen, required 6", issue_grant_q.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                checks++;
                if (issue_grant_q[i] !== exp_g[i]) begin
                    errors++;
                    $display("FAIL prio_order[%0d]: grant=%b, required %b", i, issue_grant_q[i], exp_g[i]);
                end
            end
        end
        i_req = '0;
        repeat (6) step();
    endtask

    task automatic test_random();
        int   model_last;
        int   owner;
        int   issue_cyc;
        int   txn_wait;
        int   exp_win;
        logic busy;
        logic done_pend;
        logic expect_issue;
        logic [DATA_W-1:0] exp_rd;
        logic [1+ADDR_W+DATA_W+BE_W-1:0] exp_fields;
        apply_reset();
        model_last = NUM_REQ - 1;
        owner = 0; issue_cyc = 0; txn_wait = 0; exp_win = 0;
        busy = 1'b0; done_pend = 1'b0; exp_rd = '0; exp_fields = '0;
        for (int n = 0; n < 600; n++) begin
            for (int k = 0; k < NUM_REQ; k++)
                if (!i_req[k] && $urandom_range(0, 3) == 0) new_txn(k);
            expect_issue = !busy && !done_pend && (i_req != '0);
            if (expect_issue) begin
                exp_win    = ref_pick(i_req, model_last);
                mem_wait   = $urandom_range(0, 3);
                exp_fields = {i_we[exp_win], i_addr[exp_win*ADDR_W +: ADDR_W],
                              i_wdata[exp_win*DATA_W +: DATA_W], i_be[exp_win*BE_W +: BE_W]};
                exp_rd     = mem_read(i_addr[exp_win*ADDR_W +: ADDR_W]);
            end
            step();
            if (done_pend) begin
                checks++;
                if ({o_grant, o_ack, o_mem_req} !== '0) begin
                    errors++;
                    $display("FAIL rnd_release: grant=%b ack=%b mem_req=%b, required all 0",
                             o_grant, o_ack, o_mem_req);
                end
                done_pend = 1'b0;
            end else if (expect_issue) begin
                checks++;
                if ({o_mem_req, o_grant} !== {1'b1, NUM_REQ'(1) << exp_win} ||
                    {o_mem_we, o_mem_addr, o_mem_wdata, o_mem_be} !== exp_fields) begin
                    errors++;
                    $display("FAIL rnd_issue: req=%b grant=%b fields=%h, required 1 %b %h",
                             o_mem_req, o_grant, {o_mem_we, o_mem_addr, o_mem_wdata, o_mem_be},
                             NUM_REQ'(1) << exp_win, exp_fields);
                end
                busy      = 1'b1;
                owner     = exp_win;
                issue_cyc = cyc;
                txn_wait  = mem_wait;
            end else if (!busy) begin
                checks++;
                if ({o_mem_req, o_grant} !== '0) begin
                    errors++;
                    $display("FAIL rnd_idle: mem_req=%b grant=%b, required 0 000", o_mem_req, o_grant);
                end
            end else if (o_ack !== '0) begin
                checks++;
                if (o_ack !== NUM_REQ'(1) << owner || cyc != issue_cyc + txn_wait + 1 || o_rdata !== exp_rd) begin
                    errors++;
                    $display("FAIL rnd_ack: ack=%b latency=%0d rdata=%h, required %b %0d %h",
                             o_ack, cyc - issue_cyc, o_rdata, NUM_REQ'(1) << owner, txn_wait + 1, exp_rd);
                end
                busy       = 1'b0;
                done_pend  = 1'b1;
                model_last = owner;
                if ($urandom_range(0, 1) == 1) new_txn(owner);
                else set_req(owner, 1'b0, 1'b0, 1'b0, '0, '0, '0);
            end else begin
                checks++;
                if (o_grant !== NUM_REQ'(1) << owner || cyc > issue_cyc + txn_wait + 1) begin
                    errors++;
                    $display("FAIL rnd_hold: grant=%b waited=%0d, required %b within %0d",
                             o_grant, cyc - issue_cyc, NUM_REQ'(1) << owner, txn_wait + 1);
                    break;
                end
            end
        end
        i_req = '0;
        repeat (8) step();
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        clear_logs();
        test_reset();
        test_single_read();
        test_saturation();
        test_lock_rmw();
        test_withdrawal();
        test_reset_mid_transfer();
        test_prio0();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
